gf180mcu_ocd_io__supply_seq: RTL
================================

// Module: gf180mcu_ocd_io__supply_seq
// PURPOSE
// - Supply sequencer downstream of the DVDD/DVSS/VDD/VSS pad cells in the IO ring.
// - Consumes the raw supply-good flags from the ring detectors (DVDD_OK, VDD_OK) and debounces them in order.
// - Asserts the IO enable, then releases the core reset after a fixed delay.
// - On any supply drop it re-asserts reset and counts brown-out events.
// PARAMETERS
// - DEBOUNCE_CYCLES  4      cycles each OK flag must stay high before it is accepted (>=1)
// - RELEASE_DELAY    8      cycles from both supplies accepted to core reset release (>=1)
// - TIMEOUT_CYCLES   1024   max cycles in VDD_DB before FAULT (SUPPLY_SEQ_TIMEOUT_EN only)
// - CNT_W            16     width of the shared sequence counter; must hold max(all above)-1
// PORTS
// - CLK           in   1  sequencer clock, always-on domain
// - RESETN        in   1  async active-low reset
// - DVDD_OK       in   1  async IO-supply-good flag from the ring detector
// - VDD_OK        in   1  async core-supply-good flag from the ring detector
// - CLR_FAULT     in   1  sync pulse; clears FAULT (timeout build only, else ignored)
// - IO_ENABLE     out  1  IO pad drivers may be enabled
// - CORE_RESETN   out  1  active-low core reset, high only in RUN
// - PWR_GOOD      out  1  mirrors CORE_RESETN; for status register
// - BROWNOUT_CNT  out  8  saturating count of RUN exits
// - FAULT         out  1  sticky sequencing timeout flag
// BEHAVIOUR
// - Both OK inputs pass through 2-flop synchronisers (reset 0) giving dvdd_s/vdd_s.
//   An input high before edge 0 gives dvdd_s=1 after edge 1.
// - All outputs are registered Moore decodes of state.
// - Reset values: IO_ENABLE=0, CORE_RESETN=0, PWR_GOOD=0, BROWNOUT_CNT=0, FAULT=0; state=OFF, cnt=0.
// - States: OFF, DVDD_DB, VDD_DB, RELEASE, RUN, FAULT (FAULT only with the macro).
// - OFF: dvdd_s=1 -> DVDD_DB, cnt=0.
// - DVDD_DB: dvdd_s=0 -> OFF. Otherwise cnt++.
//   At cnt==DEBOUNCE_CYCLES-1 -> VDD_DB, cnt=0. Dwell is exactly DEBOUNCE_CYCLES cycles.
// - VDD_DB: IO_ENABLE=1 (also in RELEASE and RUN). dvdd_s=0 -> OFF. vdd_s=0 -> cnt=0, stay.
//   Otherwise cnt++; at cnt==DEBOUNCE_CYCLES-1 -> RELEASE, cnt=0.
// - RELEASE: either supply low -> same exits as VDD_DB, with DVDD taking priority.
//   Otherwise cnt++; at cnt==RELEASE_DELAY-1 -> RUN.
// - RUN: CORE_RESETN=PWR_GOOD=1.
//   dvdd_s=0 -> OFF; else vdd_s=0 -> VDD_DB with cnt=0.
//   Either exit increments BROWNOUT_CNT, saturating at 255 with no wrap.
// - Simultaneous drop of both supplies: DVDD wins, state goes to OFF, one increment only.
// - A supply glitch shorter than 2 cycles may be missed by the synchroniser. This is accepted.
// - Async RESETN mid-sequence: everything returns to reset values immediately.
//   BROWNOUT_CNT clears as well.
// - The counter is never compared beyond its parameter bound.
// CONFIGURATION
// - SUPPLY_SEQ_TIMEOUT_EN defined:
//   - A second counter runs while in VDD_DB and clears on entry to VDD_DB.
//   - Reaching TIMEOUT_CYCLES -> FAULT state. FAULT output=1 and all other outputs=0.
//   - FAULT is left only by CLR_FAULT=1 -> OFF.
//   - CLR_FAULT in any other state is ignored.
// - Undefined: no FAULT state and no timeout counter. FAULT tied 0, CLR_FAULT unused.
// TESTING
// - Defaults. DVDD_OK and VDD_OK rise before edge 0.
//   -> IO_ENABLE=1 after edge 6; CORE_RESETN=PWR_GOOD=1 after edge 18.
// - DVDD_OK low for 1 sampled cycle during DVDD_DB at cnt=2 -> state OFF.
//   Re-rise -> full 4-cycle debounce restarts; no IO_ENABLE before it completes.
// - In RUN, VDD_OK low for 5 cycles.
//   -> CORE_RESETN=0 3 edges after the fall, IO_ENABLE stays 1, BROWNOUT_CNT=1.
//   -> Reset re-released 12 cycles after vdd_s returns high.
// - 300 forced VDD drops from RUN -> BROWNOUT_CNT saturates at 255.
//   Drop both supplies together -> one increment, state OFF, IO_ENABLE=0.
// - Macro defined, TIMEOUT_CYCLES=16, VDD_OK held low.
//   -> FAULT=1 after 16 cycles in VDD_DB, IO_ENABLE=0.
//   -> CLR_FAULT pulse -> OFF, then resequences normally.
// - RESETN asserted in RELEASE at cnt=5 -> all outputs 0 asynchronously.
//   Release -> sequence restarts from OFF with the edge-18 timing.

Source files
------------

// File: rtl/gf180mcu_ocd_io__supply_seq.sv
// Supply sequencer for the IO ring: debounces DVDD then VDD, enables the IO drivers,
// releases core reset after a delay and counts brown-outs. Optional timeout: SUPPLY_SEQ_TIMEOUT_EN.
module gf180mcu_ocd_io__supply_seq #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RELEASE_DELAY   = 8,
  parameter int TIMEOUT_CYCLES  = 1024,
  parameter int CNT_W           = 16
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       DVDD_OK,
  input  logic       VDD_OK,
  input  logic       CLR_FAULT,
  output logic       IO_ENABLE,
  output logic       CORE_RESETN,
  output logic       PWR_GOOD,
  output logic [7:0] BROWNOUT_CNT,
  output logic       FAULT
);

`ifdef SUPPLY_SEQ_TIMEOUT_EN
  typedef enum logic [2:0] {
    S_OFF, S_DVDD_DB, S_VDD_DB, S_RELEASE, S_RUN, S_FAULT
  } state_t;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tcnt, tcnt_n;
`else
  typedef enum logic [2:0] {
    S_OFF, S_DVDD_DB, S_VDD_DB, S_RELEASE, S_RUN
  } state_t;
  localparam int unused_timeout = TIMEOUT_CYCLES;
  logic unused_clr;
  assign unused_clr = CLR_FAULT;
`endif

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(RELEASE_DELAY - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       dvdd_sync, vdd_sync;
  logic             dvdd_s, vdd_s;
  logic             bo_inc;

  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      dvdd_sync <= '0;
      vdd_sync  <= '0;
    end else begin
      dvdd_sync <= {dvdd_sync[0], DVDD_OK};
      vdd_sync  <= {vdd_sync[0], VDD_OK};
    end
  end

  assign dvdd_s = dvdd_sync[1];
  assign vdd_s  = vdd_sync[1];

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= S_OFF;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    state_n = state;
    cnt_n   = cnt;
    bo_inc  = 1'b0;
    unique case (state)
      S_OFF: begin
        if (dvdd_s) begin
          state_n = S_DVDD_DB;
          cnt_n   = '0;
        end
      end
      S_DVDD_DB: begin
        if (!dvdd_s) begin
          state_n = S_OFF;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = S_VDD_DB;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_VDD_DB: begin
        if (!dvdd_s) begin
          state_n = S_OFF;
          cnt_n   = '0;
`ifdef SUPPLY_SEQ_TIMEOUT_EN
        end else if (tcnt == TO_LAST) begin
          state_n = S_FAULT;
          cnt_n   = '0;
`endif
        end else if (!vdd_s) begin
          cnt_n = '0;
        end else if (cnt == DB_LAST) begin
          state_n = S_RELEASE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RELEASE: begin
        if (!dvdd_s) begin
          state_n = S_OFF;
          cnt_n   = '0;
        end else if (!vdd_s) begin
          state_n = S_VDD_DB;
          cnt_n   = '0;
        end else if (cnt == REL_LAST) begin
          state_n = S_RUN;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      S_RUN: begin
        // A simultaneous drop of both supplies takes the DVDD exit and counts once.
        if (!dvdd_s) begin
          state_n = S_OFF;
          cnt_n   = '0;
          bo_inc  = 1'b1;
        end else if (!vdd_s) begin
          state_n = S_VDD_DB;
          cnt_n   = '0;
          bo_inc  = 1'b1;
        end
      end
`ifdef SUPPLY_SEQ_TIMEOUT_EN
      S_FAULT: begin
        if (CLR_FAULT) begin
          state_n = S_OFF;
          cnt_n   = '0;
        end
      end
`endif
      default: begin
        state_n = S_OFF;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef SUPPLY_SEQ_TIMEOUT_EN
  // Timeout counter restarts on every entry to VDD_DB because it is held at 0 elsewhere.
  always_comb begin
    tcnt_n = '0;
    if (state == S_VDD_DB && state_n == S_VDD_DB) tcnt_n = tcnt + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tcnt  <= '0;
      FAULT <= 1'b0;
    end else begin
      tcnt  <= tcnt_n;
      FAULT <= (state_n == S_FAULT);
    end
  end
`else
  assign FAULT = 1'b0;
`endif

  // Outputs are decoded from next state so they change on the same edge as the state.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      IO_ENABLE    <= 1'b0;
      CORE_RESETN  <= 1'b0;
      PWR_GOOD     <= 1'b0;
      BROWNOUT_CNT <= 8'd0;
    end else begin
      IO_ENABLE   <= (state_n == S_VDD_DB) || (state_n == S_RELEASE) || (state_n == S_RUN);
      CORE_RESETN <= (state_n == S_RUN);
      PWR_GOOD    <= (state_n == S_RUN);
      if (bo_inc && (BROWNOUT_CNT != 8'hFF)) BROWNOUT_CNT <= BROWNOUT_CNT + 8'd1;
    end
  end

endmodule
